// File: rtl/axis_governor_replay.sv
// Capture/replay buffer for the axis_governor log stream: records whole packets in CAPTURE
// and plays the stored flits back on the inject stream in REPLAY, once or looped.
module axis_governor_replay #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 16,
  parameter int ID_WIDTH   = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   log_TDATA,
  input  logic                    log_TVALID,
  output logic                    log_TREADY,
  input  logic [DATA_WIDTH/8-1:0] log_TKEEP,
  input  logic [DEST_WIDTH-1:0]   log_TDEST,
  input  logic [ID_WIDTH-1:0]     log_TID,
  input  logic                    log_TLAST,
  output logic [DATA_WIDTH-1:0]   inj_TDATA,
  output logic                    inj_TVALID,
  input  logic                    inj_TREADY,
  output logic [DATA_WIDTH/8-1:0] inj_TKEEP,
  output logic [DEST_WIDTH-1:0]   inj_TDEST,
  output logic [ID_WIDTH-1:0]     inj_TID,
  output logic                    inj_TLAST,
  input  logic                    capture_en,
  input  logic                    replay_start,
  input  logic                    replay_loop,
  input  logic                    clear,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    overflow,
  output logic                    busy
);
  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = DATA_WIDTH + KEEP_W + DEST_WIDTH + ID_WIDTH + 1;
  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [ENTRY_W-1:0]    ENT_ZERO = {ENTRY_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REPLAY  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    mid_q, mid_d;
  logic                    rdy_q;
  logic                    busy_q, busy_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [ENTRY_W-1:0]      out_q, out_d;
  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [ENTRY_W-1:0]      mem_rd_q;
  logic [ENTRY_W-1:0]      wr_entry;
  logic [DEPTH_LOG2:0]     last_idx;
  logic                    wr_en, rd_en, log_hs, inj_hs, out_load, rd_last;

  assign wr_entry = {log_TDATA, log_TKEEP, log_TDEST, log_TID, log_TLAST};
  assign log_hs   = log_TVALID & rdy_q;
  assign inj_hs   = out_valid_q & inj_TREADY;
  // mem_rd_q acts as the prefetch/skid stage feeding the registered output flit
  assign out_load = rvalid_q & (~out_valid_q | inj_TREADY);
  assign last_idx = count_q - CNT_ONE;
  assign rd_last  = ({1'b0, rd_ptr_q} == last_idx);

  // Next-state, capture bookkeeping and replay pipeline control
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    mid_d       = mid_q;
    rd_ptr_d    = rd_ptr_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_d       = out_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture_en) begin
          state_d = ST_CAPTURE;
        end else if (clear) begin
          count_d = CNT_ZERO;
          ovf_d   = 1'b0;
        end else if (replay_start && (count_q != CNT_ZERO)) begin
          state_d     = ST_REPLAY;
          rd_ptr_d    = PTR_ZERO;
          rvalid_d    = 1'b0;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (log_hs) begin
          mid_d = ~log_TLAST;
          if (count_q != CNT_FULL) begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          mid_d = mid_q;
        end
        if (!capture_en && !mid_d) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_REPLAY: begin
        if (out_load) begin
          out_d       = mem_rd_q;
          out_last_d  = rlast_q;
          out_valid_d = 1'b1;
        end else if (inj_hs) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        // Reads always wrap; a non-looping pass discards the prefetched entry 0 on stop
        rd_en = ~rvalid_q | out_load;
        if (rd_en) begin
          rvalid_d = 1'b1;
          rlast_d  = rd_last;
          rd_ptr_d = rd_last ? PTR_ZERO : (rd_ptr_q + PTR_ONE);
        end else begin
          rvalid_d = rvalid_q;
        end
        if (inj_hs && out_last_q && !replay_loop) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          rvalid_d    = 1'b0;
        end else begin
          state_d = ST_REPLAY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= CNT_ZERO;
      ovf_q       <= 1'b0;
      mid_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_ptr_q    <= PTR_ZERO;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= ENT_ZERO;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      mid_q       <= mid_d;
      rdy_q       <= 1'b1;
      busy_q      <= busy_d;
      rd_ptr_q    <= rd_ptr_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_q       <= out_d;
    end
  end

  // Flit buffer with one-cycle synchronous read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[DEPTH_LOG2-1:0]] <= wr_entry;
    end
    if (rd_en) begin
      mem_rd_q <= mem[rd_ptr_q];
    end
  end

  assign {inj_TDATA, inj_TKEEP, inj_TDEST, inj_TID, inj_TLAST} = out_q;
  assign inj_TVALID = out_valid_q;
  assign log_TREADY = rdy_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_axis_governor_replay.sv
// Randomized bench for axis_governor_replay checked against a queue-based model of the
// capture buffer and replay sequence.
module tb_axis_governor_replay;
  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int DESTW = 16;
  localparam int IDW   = 16;
  localparam int DL2   = 6;
  localparam int DEPTH = 64;
  localparam int EW    = DW + KW + DESTW + IDW + 1;

  typedef logic [EW-1:0] entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    log_TDATA = '0;
  logic             log_TVALID = 1'b0;
  logic             log_TREADY;
  logic [KW-1:0]    log_TKEEP = '0;
  logic [DESTW-1:0] log_TDEST = '0;
  logic [IDW-1:0]   log_TID = '0;
  logic             log_TLAST = 1'b0;
  logic [DW-1:0]    inj_TDATA;
  logic             inj_TVALID;
  logic             inj_TREADY = 1'b0;
  logic [KW-1:0]    inj_TKEEP;
  logic [DESTW-1:0] inj_TDEST;
  logic [IDW-1:0]   inj_TID;
  logic             inj_TLAST;
  logic             capture_en = 1'b0;
  logic             replay_start = 1'b0;
  logic             replay_loop = 1'b0;
  logic             clear = 1'b0;
  logic [DL2:0]     count;
  logic             overflow;
  logic             busy;

  always #5 clk = ~clk;

  axis_governor_replay #(.DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .ID_WIDTH(IDW), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst),
    .log_TDATA(log_TDATA), .log_TVALID(log_TVALID), .log_TREADY(log_TREADY), .log_TKEEP(log_TKEEP),
    .log_TDEST(log_TDEST), .log_TID(log_TID), .log_TLAST(log_TLAST),
    .inj_TDATA(inj_TDATA), .inj_TVALID(inj_TVALID), .inj_TREADY(inj_TREADY), .inj_TKEEP(inj_TKEEP),
    .inj_TDEST(inj_TDEST), .inj_TID(inj_TID), .inj_TLAST(inj_TLAST),
    .capture_en(capture_en), .replay_start(replay_start), .replay_loop(replay_loop), .clear(clear),
    .count(count), .overflow(overflow), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 capture, 2 replay
  entry_t m_buf[$];
  int     m_mode = 0;
  bit     m_ovf = 1'b0, m_mid = 1'b0, m_rdy = 1'b0;
  int     m_idx = 0, m_hs = 0, m_edges = 0;
  bit     m_first = 1'b0, m_prev_stall = 1'b0;
  entry_t m_prev_pl;

  function automatic entry_t inj_pl();
    return {inj_TDATA, inj_TKEEP, inj_TDEST, inj_TID, inj_TLAST};
  endfunction

  function automatic entry_t log_pl();
    return {log_TDATA, log_TKEEP, log_TDEST, log_TID, log_TLAST};
  endfunction

  // One clock cycle: model update from the inputs now applied, then post-edge checks
  task automatic tick();
    int nm = m_mode;
    bit rst_now = rst;
    if (m_prev_stall) begin
      check_val("stall_valid", inj_TVALID, 1);
      check_val("stall_hold", inj_pl(), m_prev_pl);
    end
    m_prev_stall = inj_TVALID && !inj_TREADY;
    m_prev_pl = inj_pl();
    case (m_mode)
      0: begin
        if (capture_en) nm = 1;
        else if (clear) begin m_buf.delete(); m_ovf = 1'b0; end
        else if (replay_start && m_buf.size() > 0) begin
          nm = 2; m_idx = 0; m_first = 1'b1; m_edges = -1;
        end
      end
      1: begin
        if (log_TVALID && m_rdy) begin
          if (m_buf.size() < DEPTH) m_buf.push_back(log_pl());
          else m_ovf = 1'b1;
          m_mid = !log_TLAST;
        end
        if (!capture_en && !m_mid) nm = 0;
      end
      default: begin
        if (inj_TVALID && inj_TREADY && !m_first) begin
          check_val("inj_flit", inj_pl(), m_buf[m_idx]);
          m_hs++;
          if (m_idx == m_buf.size() - 1) begin
            m_idx = 0;
            if (!replay_loop) nm = 0;
          end else m_idx++;
        end
      end
    endcase
    if (rst_now) begin
      m_buf.delete(); m_ovf = 1'b0; m_mid = 1'b0; nm = 0; m_prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    m_mode = nm;
    m_rdy = !rst_now;
    check_val("count", count, m_buf.size());
    check_val("overflow", overflow, m_ovf);
    check_val("busy", busy, m_mode != 0);
    check_val("log_ready", log_TREADY, m_rdy);
    if (m_mode == 2) begin
      m_edges++;
      if (m_first) begin
        check_val("first_valid", inj_TVALID, m_edges == 2);
        if (m_edges == 2) m_first = 1'b0;
      end else check_val("no_bubble", inj_TVALID, 1);
    end else check_val("idle_valid", inj_TVALID, 0);
    if (rst_now) check_val("rst_inj", inj_pl(), 0);
  endtask

  task automatic send_flit(input logic [DW-1:0] d, input logic [DESTW-1:0] dst,
                           input logic [IDW-1:0] id, input bit last);
    while ($urandom_range(0, 3) == 0) tick();
    log_TVALID = 1'b1; log_TDATA = d; log_TKEEP = KW'($urandom);
    log_TDEST = dst; log_TID = id; log_TLAST = last;
    tick();
    log_TVALID = 1'b0;
  endtask

  task automatic pulse_start();
    replay_start = 1'b1; tick(); replay_start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && m_mode != 0; i++) tick();
    check_val(tag, busy, 0);
  endtask

  task automatic capture_pkts(input int npkt, input int len);
    capture_en = 1'b1; tick();
    for (int p = 0; p < npkt; p++)
      for (int f = 0; f < len; f++)
        send_flit({$urandom, $urandom}, DESTW'($urandom), IDW'($urandom), f == len - 1);
    capture_en = 1'b0;
    wait_idle("cap_idle", 20);
  endtask

  initial begin
    int h0;
    rst = 1'b1; tick(); tick();
    check_val("rst_count", count, 0);
    check_val("rst_ready", log_TREADY, 0);
    rst = 1'b0; tick();

    // Basic capture of one 3-flit packet and replay, twice
    capture_en = 1'b1; tick();
    send_flit(64'h11, 16'd5, 16'd7, 1'b0);
    send_flit(64'h22, 16'd5, 16'd7, 1'b0);
    send_flit(64'h33, 16'd5, 16'd7, 1'b1);
    capture_en = 1'b0; wait_idle("cap3_idle", 10);
    check_val("cap3_count", count, 3);
    check_val("cap3_ovf", overflow, 0);
    inj_TREADY = 1'b1;
    for (int r = 0; r < 2; r++) begin
      h0 = m_hs; pulse_start(); wait_idle("rep3_idle", 20);
      check_val("rep3_flits", m_hs - h0, 3);
    end

    // Overflow
    pulse_clear();
    capture_pkts(70, 1);
    check_val("ovf_count", count, 64);
    check_val("ovf_flag", overflow, 1);
    pulse_clear();
    check_val("clr_count", count, 0);
    check_val("clr_ovf", overflow, 0);

    // Packet alignment: capture_en dropped after flit 2 of 5
    capture_en = 1'b1; tick();
    for (int f = 0; f < 5; f++) begin
      if (f == 2) capture_en = 1'b0;
      send_flit({$urandom, $urandom}, 16'd1, 16'd2, f == 4);
    end
    check_val("align_count", count, 5);
    check_val("align_idle", busy, 0);

    // Backpressure replay of 8 entries
    pulse_clear();
    capture_pkts(2, 4);
    h0 = m_hs; pulse_start();
    for (int i = 0; i < 300 && m_mode != 0; i++) begin
      inj_TREADY = $urandom_range(0, 1); tick();
    end
    check_val("bp_idle", busy, 0);
    check_val("bp_flits", m_hs - h0, 8);

    // Loop over 3 entries, stop during the second pass
    pulse_clear();
    capture_pkts(1, 3);
    inj_TREADY = 1'b1; replay_loop = 1'b1;
    h0 = m_hs; pulse_start();
    for (int i = 0; i < 50 && (m_hs - h0) < 4; i++) tick();
    replay_loop = 1'b0;
    wait_idle("loop_idle", 20);
    check_val("loop_flits", m_hs - h0, 6);

    // Reset during replay of entry 1
    h0 = m_hs; pulse_start();
    for (int i = 0; i < 20 && (m_hs - h0) < 1; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("rst_valid", inj_TVALID, 0);
    check_val("rst_cnt", count, 0);
    check_val("rst_busy", busy, 0);
    tick(); pulse_start(); tick(); tick();
    check_val("rst_nostart", busy, 0);

    // Random mixed operation
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) capture_en = ~capture_en;
      if ($urandom_range(0, 14) == 0) replay_loop = ~replay_loop;
      replay_start = ($urandom_range(0, 9) == 0);
      clear = ($urandom_range(0, 29) == 0);
      log_TVALID = $urandom_range(0, 1);
      log_TDATA = {$urandom, $urandom}; log_TKEEP = KW'($urandom);
      log_TDEST = DESTW'($urandom); log_TID = IDW'($urandom);
      log_TLAST = ($urandom_range(0, 2) == 0);
      inj_TREADY = ($urandom_range(0, 3) != 0);
      tick();
    end
    capture_en = 1'b0; replay_loop = 1'b0; replay_start = 1'b0; clear = 1'b0;
    log_TLAST = 1'b1; inj_TREADY = 1'b1;
    wait_idle("rand_idle", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
